// File: rtl/ls_stage.sv
// ls_stage: memory-access stage downstream of EX.
// Slot 0 performs one load/store at a time over a valid/ready data bus while
// the pipeline is stalled; every slot is then presented to the writeback regs.
// Build option: define NCPU_LSU_MISALIGN_EXC_EN to trap misaligned accesses
// instead of silently clearing the low address bits.

`ifndef NCPU_REG_AW
`define NCPU_REG_AW 5
`endif

module ls_stage #(
    parameter int  CONFIG_P_ISSUE_WIDTH = 1,
    parameter int  CONFIG_DW            = 64,
    parameter int  CONFIG_AW            = 64,
    localparam int IW                   = 1 << CONFIG_P_ISSUE_WIDTH,
    localparam int RAW                  = `NCPU_REG_AW
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic [IW-1:0]           ls_valid,
    input  logic [CONFIG_DW*IW-1:0] ls_rf_dout,
    input  logic [RAW*IW-1:0]       ls_rf_waddr,
    input  logic [IW-1:0]           ls_rf_we,
    input  logic                    ls_lsu_load,
    input  logic                    ls_lsu_store,
    input  logic [1:0]              ls_lsu_size,
    input  logic                    ls_lsu_sext,
    input  logic [CONFIG_AW-1:0]    ls_lsu_addr,
    input  logic [CONFIG_DW-1:0]    ls_lsu_wdat,
    output logic                    stall_req,
    output logic                    dbus_req_valid,
    input  logic                    dbus_req_ready,
    output logic                    dbus_req_we,
    output logic [CONFIG_AW-1:0]    dbus_req_addr,
    output logic [CONFIG_DW-1:0]    dbus_req_wdat,
    output logic [7:0]              dbus_req_wmsk,
    input  logic                    dbus_resp_valid,
    input  logic [CONFIG_DW-1:0]    dbus_resp_rdat,
    input  logic                    dbus_resp_err,
    output logic [IW-1:0]           wb_valid,
    output logic [CONFIG_DW*IW-1:0] wb_rf_dout,
    output logic [RAW*IW-1:0]       wb_rf_waddr,
    output logic [IW-1:0]           wb_rf_we,
    output logic                    wb_exc_buserr,
    output logic                    wb_exc_misalign
);

    typedef enum logic [1:0] {IDLE, REQ, RESP, DRAIN} state_e;

    state_e                    state_q, state_d;
    logic [IW-1:0]             bnd_valid_q, bnd_valid_d;
    logic [CONFIG_DW*IW-1:0]   bnd_dout_q, bnd_dout_d;
    logic [RAW*IW-1:0]         bnd_waddr_q, bnd_waddr_d;
    logic [IW-1:0]             bnd_we_q, bnd_we_d;
    logic                      is_store_q, is_store_d;
    logic [1:0]                size_q, size_d;
    logic                      sext_q, sext_d;
    logic [2:0]                lane_q, lane_d;
    logic [CONFIG_AW-4:0]      addr_hi_q, addr_hi_d;
    logic [CONFIG_DW-1:0]      wdat_q, wdat_d;
    logic [7:0]                wmsk_q, wmsk_d;
    logic [IW-1:0]             wb_valid_q, wb_valid_d;
    logic [CONFIG_DW*IW-1:0]   wb_rf_dout_q, wb_rf_dout_d;
    logic [RAW*IW-1:0]         wb_rf_waddr_q, wb_rf_waddr_d;
    logic [IW-1:0]             wb_rf_we_q, wb_rf_we_d;
    logic                      wb_exc_buserr_q, wb_exc_buserr_d;
    logic                      wb_exc_misalign_q, wb_exc_misalign_d;

    logic [2:0]                size_lsb;
    logic [7:0]                size_bmsk;
    logic                      misaligned;
    logic [CONFIG_AW-1:0]      addr_eff;
    logic                      mem_op;
    logic                      start;
    logic                      misalign_hit;
    logic [CONFIG_DW-1:0]      wdat_sh;
    logic [7:0]                wmsk_sh;
    logic [CONFIG_DW-1:0]      rdat_sh;
    logic [CONFIG_DW-1:0]      load_res;

    // Decode access size into the address bits that must be zero and the byte-lane mask
    always_comb begin
        size_lsb  = 3'b000;
        size_bmsk = 8'h01;
        case (ls_lsu_size)
            2'd0:    begin size_lsb = 3'b000; size_bmsk = 8'h01; end
            2'd1:    begin size_lsb = 3'b001; size_bmsk = 8'h03; end
            2'd2:    begin size_lsb = 3'b011; size_bmsk = 8'h0F; end
            default: begin size_lsb = 3'b111; size_bmsk = 8'hFF; end
        endcase
    end

`ifdef NCPU_LSU_MISALIGN_EXC_EN
    assign misaligned = |(ls_lsu_addr[2:0] & size_lsb);
    assign addr_eff   = ls_lsu_addr;
`else
    assign misaligned = 1'b0;
    assign addr_eff   = {ls_lsu_addr[CONFIG_AW-1:3], ls_lsu_addr[2:0] & ~size_lsb};
`endif

    assign mem_op       = ls_valid[0] & (ls_lsu_load | ls_lsu_store);
    assign start        = mem_op & ~flush & ~misaligned;
    assign misalign_hit = mem_op & ~flush & misaligned;
    assign wdat_sh      = ls_lsu_wdat << {addr_eff[2:0], 3'b000};
    assign wmsk_sh      = size_bmsk << addr_eff[2:0];
    assign rdat_sh      = dbus_resp_rdat >> {lane_q, 3'b000};

    // Trim the lane-aligned read data to the access size and extend it
    always_comb begin
        load_res = rdat_sh;
        case (size_q)
            2'd0:    load_res = {{56{sext_q & rdat_sh[7]}},  rdat_sh[7:0]};
            2'd1:    load_res = {{48{sext_q & rdat_sh[15]}}, rdat_sh[15:0]};
            2'd2:    load_res = {{32{sext_q & rdat_sh[31]}}, rdat_sh[31:0]};
            default: load_res = rdat_sh;
        endcase
    end

    // Next-state, stall and writeback selection for the access FSM
    always_comb begin
        state_d           = state_q;
        bnd_valid_d       = bnd_valid_q;
        bnd_dout_d        = bnd_dout_q;
        bnd_waddr_d       = bnd_waddr_q;
        bnd_we_d          = bnd_we_q;
        is_store_d        = is_store_q;
        size_d            = size_q;
        sext_d            = sext_q;
        lane_d            = lane_q;
        addr_hi_d         = addr_hi_q;
        wdat_d            = wdat_q;
        wmsk_d            = wmsk_q;
        wb_valid_d        = '0;
        wb_rf_dout_d      = wb_rf_dout_q;
        wb_rf_waddr_d     = wb_rf_waddr_q;
        wb_rf_we_d        = wb_rf_we_q;
        wb_exc_buserr_d   = 1'b0;
        wb_exc_misalign_d = 1'b0;
        stall_req         = 1'b0;
        dbus_req_valid    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    stall_req   = 1'b1;
                    bnd_valid_d = ls_valid;
                    bnd_dout_d  = ls_rf_dout;
                    bnd_waddr_d = ls_rf_waddr;
                    bnd_we_d    = ls_rf_we;
                    is_store_d  = ls_lsu_store;
                    size_d      = ls_lsu_size;
                    sext_d      = ls_lsu_sext;
                    lane_d      = addr_eff[2:0];
                    addr_hi_d   = addr_eff[CONFIG_AW-1:3];
                    wdat_d      = wdat_sh;
                    wmsk_d      = wmsk_sh;
                    state_d     = REQ;
                end else begin
                    wb_rf_dout_d  = ls_rf_dout;
                    wb_rf_waddr_d = ls_rf_waddr;
                    wb_rf_we_d    = ls_rf_we;
                    if (misalign_hit) begin
                        wb_valid_d[0]     = 1'b1;
                        wb_rf_we_d[0]     = 1'b0;
                        wb_exc_misalign_d = 1'b1;
                    end else if (!flush) begin
                        wb_valid_d = ls_valid;
                    end
                end
            end
            REQ: begin
                stall_req      = 1'b1;
                dbus_req_valid = 1'b1;
                if (flush) begin
                    state_d = dbus_req_ready ? DRAIN : IDLE;
                end else if (dbus_req_ready) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (dbus_resp_valid) begin
                    state_d = IDLE;
                    if (!flush) begin
                        wb_valid_d    = bnd_valid_q;
                        wb_rf_dout_d  = bnd_dout_q;
                        wb_rf_waddr_d = bnd_waddr_q;
                        wb_rf_we_d    = bnd_we_q;
                        if (dbus_resp_err) begin
                            wb_valid_d      = '0;
                            wb_valid_d[0]   = 1'b1;
                            wb_rf_we_d[0]   = 1'b0;
                            wb_exc_buserr_d = 1'b1;
                        end else if (!is_store_q) begin
                            wb_rf_dout_d[CONFIG_DW-1:0] = load_res;
                        end
                    end
                end else begin
                    stall_req = 1'b1;
                    if (flush) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                stall_req = 1'b1;
                if (dbus_resp_valid) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, captured bundle and writeback registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q           <= IDLE;
            bnd_valid_q       <= '0;
            bnd_dout_q        <= '0;
            bnd_waddr_q       <= '0;
            bnd_we_q          <= '0;
            is_store_q        <= 1'b0;
            size_q            <= 2'd0;
            sext_q            <= 1'b0;
            lane_q            <= 3'd0;
            addr_hi_q         <= '0;
            wdat_q            <= '0;
            wmsk_q            <= 8'h00;
            wb_valid_q        <= '0;
            wb_rf_dout_q      <= '0;
            wb_rf_waddr_q     <= '0;
            wb_rf_we_q        <= '0;
            wb_exc_buserr_q   <= 1'b0;
            wb_exc_misalign_q <= 1'b0;
        end else begin
            state_q           <= state_d;
            bnd_valid_q       <= bnd_valid_d;
            bnd_dout_q        <= bnd_dout_d;
            bnd_waddr_q       <= bnd_waddr_d;
            bnd_we_q          <= bnd_we_d;
            is_store_q        <= is_store_d;
            size_q            <= size_d;
            sext_q            <= sext_d;
            lane_q            <= lane_d;
            addr_hi_q         <= addr_hi_d;
            wdat_q            <= wdat_d;
            wmsk_q            <= wmsk_d;
            wb_valid_q        <= wb_valid_d;
            wb_rf_dout_q      <= wb_rf_dout_d;
            wb_rf_waddr_q     <= wb_rf_waddr_d;
            wb_rf_we_q        <= wb_rf_we_d;
            wb_exc_buserr_q   <= wb_exc_buserr_d;
            wb_exc_misalign_q <= wb_exc_misalign_d;
        end
    end

    assign dbus_req_we     = is_store_q;
    assign dbus_req_addr   = {addr_hi_q, 3'b000};
    assign dbus_req_wdat   = wdat_q;
    assign dbus_req_wmsk   = wmsk_q;
    assign wb_valid        = wb_valid_q;
    assign wb_rf_dout      = wb_rf_dout_q;
    assign wb_rf_waddr     = wb_rf_waddr_q;
    assign wb_rf_we        = wb_rf_we_q;
    assign wb_exc_buserr   = wb_exc_buserr_q;
    assign wb_exc_misalign = wb_exc_misalign_q;

endmodule

// File: doc/ls_stage.md
# ls_stage

Memory-access stage directly downstream of the execute stage. Captures each issued bundle from EX, performs slot 0's load/store over a single-outstanding valid/ready data bus, and stalls the pipeline until the access completes. Aligns and sign-extends load data, then presents the bundle (ALU results plus load result) to the writeback registers. Slot 0 is the only memory slot; slots 1..IW-1 carry ALU results only.

## Interface
- CONFIG_P_ISSUE_WIDTH, 1, log2 of issue width; IW = 1<<CONFIG_P_ISSUE_WIDTH.
- CONFIG_DW, 64, data width; fixed at 64 (8 byte lanes).
- CONFIG_AW, 64, data address width.
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- flush  in  1  pipeline flush from commit/exception logic.
- ls_valid  in  IW  per-slot valid from EX.
- ls_rf_dout  in  CONFIG_DW*IW  EX results.
- ls_rf_waddr  in  `NCPU_REG_AW*IW  destination registers.
- ls_rf_we  in  IW  register write enables.
- ls_lsu_load, ls_lsu_store  in  1 each  slot-0 memory op; never both high.
- ls_lsu_size  in  2  0=byte, 1=half, 2=word, 3=dword.
- ls_lsu_sext  in  1  sign-extend load result.
- ls_lsu_addr  in  CONFIG_AW  effective address.
- ls_lsu_wdat  in  CONFIG_DW  store data, right-aligned.
- stall_req  out  1  freezes EX and all upstream stages.
- dbus_req_valid  out  1;  dbus_req_ready  in  1.
- dbus_req_we  out  1;  dbus_req_addr  out  CONFIG_AW (8-byte aligned);  dbus_req_wdat  out  CONFIG_DW;  dbus_req_wmsk  out  8.
- dbus_resp_valid  in  1;  dbus_resp_rdat  in  CONFIG_DW;  dbus_resp_err  in  1.
- wb_valid  out  IW;  wb_rf_dout  out  CONFIG_DW*IW;  wb_rf_waddr  out  `NCPU_REG_AW*IW;  wb_rf_we  out  IW.
- wb_exc_buserr, wb_exc_misalign  out  1 each  exception flags for slot 0.

## Operation
- FSM states: IDLE, REQ, RESP, DRAIN. Reset: IDLE. All outputs reset to 0.
- IDLE, no memory op in slot 0, or ls_valid[0]=0: bundle registered into wb_* next edge.
- IDLE, ls_valid[0] & (load|store) & ~flush: latch bundle, address, size, sext, and lane-shifted wdat/wmsk. Go to REQ. stall_req=1 combinationally this cycle.
- REQ: dbus_req_valid=1, request fields are stable. On ready, go to RESP.
- RESP: on resp_valid, form the result, load wb_*, and go to IDLE.
- Load result: shift rdat right by addr[2:0]*8, mask to size, and sign-/zero-extend per sext.
- Store: wb_rf_we[0] is the latched value (normally 0).
- Bus error (resp_err=1): wb_exc_buserr=1, wb_valid[0]=1, wb_rf_we[0]=0, and wb_valid[IW-1:1]=0.
- wb_valid=0 (bubble) in every cycle the FSM is not completing. Exception flags are valid only with wb_valid[0].
- flush:
  - In IDLE or REQ without handshake: go to IDLE, no request issued, wb_valid cleared next edge.
  - In REQ with handshake in the same cycle, or in RESP: go to DRAIN.
  - DRAIN: discard the response, then go to IDLE with no wb output. stall_req stays 1 in DRAIN.
- stall_req = (state != IDLE) | IDLE-start condition. It is deasserted in the cycle resp_valid is accepted in RESP.

## Timing
- Non-memory bundle: 1-cycle latency.
- Memory bundle, zero-wait bus: cycle 0 capture; cycle 1 REQ with handshake; cycle 2 RESP with resp_valid; wb_valid in cycle 3. Minimum 3 cycles. Each wait cycle on ready or resp adds 1.
- Bus rules:
  - req fields must not change while valid is high and ready is low.
  - At most one outstanding request.
  - resp_valid is ignored outside RESP/DRAIN.
- Async reset mid-transaction: the FSM goes to IDLE immediately. The bus slave is reset by the same rst.

## Configuration
- NCPU_LSU_MISALIGN_EXC_EN defined: an access with addr not aligned to its size issues no bus request and completes in 1 cycle. The result is wb_exc_misalign=1, wb_valid[0]=1, wb_rf_we[0]=0, and the other slots are invalidated.
- Undefined: no check. Address low bits are cleared to size alignment before use, and wb_exc_misalign is tied to 0.

## Test plan
- ALU-only bundle (valid=2'b11, douts 0x11/0x22) -> wb_valid=2'b11 next cycle with the same data; stall_req stays 0.
- Load byte, sext=1, addr 0x1003, rdat 0x0000_0000_8000_0000, zero-wait bus -> req addr 0x1000, wb_rf_dout[0]=0xFFFF_FFFF_FFFF_FF80 at cycle 3.
- Store half, addr 0x2006, wdat 0xBEEF, ready delayed 2 cycles -> wmsk=0xC0, wdat[63:48]=0xBEEF, fields stable while waiting; stall_req high until the response.
- Load with resp_err=1 -> wb_exc_buserr=1, wb_rf_we[0]=0, wb_valid=2'b01.
- flush in RESP, response 3 cycles later -> FSM in DRAIN, no wb_valid, then IDLE; the next load completes normally.
- Macro defined, word load at addr 0x3002 -> no dbus_req_valid, wb_exc_misalign=1 next cycle. Undefined -> request to 0x3000 with data from lanes 0-3.
